// File: rtl/sched_pkg.sv
// Shared types and constants for the command scheduler: command width,
// issue-FSM states and the decode-stage command codes.
package sched_pkg;

    localparam int CMD_W = 5;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    // bit 4 set selects the compute (PIM/PNM) port, clear selects load/store
    localparam logic [CMD_W-1:0] ADDF    = 5'b10000;
    localparam logic [CMD_W-1:0] MULF    = 5'b10010;
    localparam logic [CMD_W-1:0] RELU    = 5'b11000;
    localparam logic [CMD_W-1:0] MAXPOOL = 5'b11001;
    localparam logic [CMD_W-1:0] MOVE    = 5'b11011;
    localparam logic [CMD_W-1:0] LBU     = 5'b01011;
    localparam logic [CMD_W-1:0] LHU     = 5'b01010;
    localparam logic [CMD_W-1:0] LW      = 5'b01001;
    localparam logic [CMD_W-1:0] SB      = 5'b00011;
    localparam logic [CMD_W-1:0] SH      = 5'b00010;
    localparam logic [CMD_W-1:0] SW      = 5'b00001;
    localparam logic [CMD_W-1:0] NOP     = 5'b00000;

    function automatic logic is_pim(input logic [CMD_W-1:0] cmd);
        return cmd[CMD_W-1];
    endfunction

endpackage

// File: rtl/sched_if.sv
// Scheduler bus: upstream command push, mem and pim issue ports, status.
interface sched_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) ();
    import sched_pkg::*;

    logic                   in_valid;
    logic                   in_ready;
    logic [CMD_W-1:0]       in_cmd;
    logic [AW-1:0]          in_addr;
    logic                   mem_valid;
    logic                   mem_ready;
    logic [CMD_W-1:0]       mem_cmd;
    logic [AW-1:0]          mem_addr;
    logic                   pim_valid;
    logic                   pim_ready;
    logic [CMD_W-1:0]       pim_cmd;
    logic [AW-1:0]          pim_addr;
    logic                   pim_done;
    logic [$clog2(DEPTH):0] occupancy;
    logic                   illegal;

    modport slave (
        input  in_valid, in_cmd, in_addr, mem_ready, pim_ready, pim_done,
        output in_ready, mem_valid, mem_cmd, mem_addr,
               pim_valid, pim_cmd, pim_addr, occupancy, illegal
    );

    modport master (
        output in_valid, in_cmd, in_addr, mem_ready, pim_ready, pim_done,
        input  in_ready, mem_valid, mem_cmd, mem_addr,
               pim_valid, pim_cmd, pim_addr, occupancy, illegal
    );

endinterface

// File: rtl/sched_fifo.sv
// Power-of-two command queue; pointers wrap naturally at DEPTH.
module sched_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 21
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic [W-1:0]           din,
    input  logic                   pop,
    output logic [W-1:0]           dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_ok && !pop_ok)      count_d = count_q + CW'(1);
        else if (!push_ok && pop_ok) count_d = count_q - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage needs no reset: entries are only read once counted in
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/sched_issue.sv
// In-order command scheduler: queues decoded commands and issues each one to
// the load/store or compute port, holding issue while compute is in flight.
module sched_issue
    import sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 16
) (
    input  logic   clk,
    input  logic   rst_n,
    sched_if.slave bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = CMD_W + AW;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic             push, pop, full, empty;
    logic [W-1:0]     head;
    logic [CMD_W-1:0] head_cmd;
    logic [AW-1:0]    head_addr;
    logic [CW-1:0]    count;
    logic             accept, mem_valid, pim_valid;

    assign accept = bus.in_valid && !full;
    assign push   = accept && (bus.in_cmd != NOP);

    sched_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   ({bus.in_cmd, bus.in_addr}),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign head_cmd  = head[W-1:AW];
    assign head_addr = head[AW-1:0];

    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        pim_valid = 1'b0;
        pop       = 1'b0;
        illegal_d = accept && (bus.in_cmd == NOP);
        case (state_q)
            IDLE: begin
                if (!empty) state_d = ISSUE;
            end
            ISSUE: begin
                if (!is_pim(head_cmd)) begin
                    mem_valid = 1'b1;
                    if (bus.mem_ready) begin
                        pop = 1'b1;
                        // queue drains only if this was the last entry and nothing arrives
                        if (count == CW'(1) && !push) state_d = IDLE;
                    end
                end else begin
                    pim_valid = 1'b1;
                    if (bus.pim_ready) begin
                        pop     = 1'b1;
                        state_d = WAIT_DONE;
                    end
                end
            end
            WAIT_DONE: begin
                if (bus.pim_done) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    assign bus.in_ready  = !full;
    assign bus.occupancy = count;
    assign bus.illegal   = illegal_q;
    assign bus.mem_valid = mem_valid;
    assign bus.mem_cmd   = head_cmd;
    assign bus.mem_addr  = head_addr;
    assign bus.pim_valid = pim_valid;
    assign bus.pim_cmd   = head_cmd;
    assign bus.pim_addr  = head_addr;

endmodule
